// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state codes, the
// default frame marker and the error-cause codes used for debug visibility.
package uart_prog_loader_pkg;

  localparam logic [2:0] stIDLE  = 3'd0;
  localparam logic [2:0] stCOUNT = 3'd1;
  localparam logic [2:0] stDATA  = 3'd2;
  localparam logic [2:0] stWR_LO = 3'd3;
  localparam logic [2:0] stWR_HI = 3'd4;
  localparam logic [2:0] stCHECK = 3'd5;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_RANGE    = 3'd1,
    ERR_CHECKSUM = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_OVERRUN  = 3'd4
  } err_cause_e;

  // Largest legal COUNT: half the nibble memory depth, in bytes.
  function automatic logic [7:0] max_count(input int addr_width);
    return 8'(32'd1 << (addr_width - 1));
  endfunction

endpackage

// File: rtl/uart_prog_loader_timeout.sv
// Inter-byte watchdog: a clearable, enabled counter that flags the cycle in
// which it would reach TIMEOUT_CYCLES.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES   = 1000000,
  parameter int TIMEOUT_BITWIDTH = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TIMEOUT_BITWIDTH-1:0] LAST = TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_BITWIDTH-1:0] ONE  = TIMEOUT_BITWIDTH'(1);

  logic [TIMEOUT_BITWIDTH-1:0] count_r;

  // Idle-cycle counter, restarted by every clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {TIMEOUT_BITWIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {TIMEOUT_BITWIDTH{1'b0}};
    end else if (en) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // A clear in the terminal cycle wins, so a byte arriving just in time is accepted.
  assign tc = en && !clr && (count_r == LAST);

endmodule

// File: rtl/uart_prog_loader.sv
// Framed program-download parser: SYNC, COUNT, data bytes, CHECKSUM. Each data
// byte is written low nibble first into the nibble-wide CPU program memory.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH       = 5,
  parameter logic [7:0]  SYNC_BYTE        = SYNC_BYTE_DEFAULT,
  parameter int          TIMEOUT_CYCLES   = 1000000,
  parameter int          TIMEOUT_BITWIDTH = 20
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_strb_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_wdata_o,
  output logic                  cpu_halt_o,
  output logic                  load_done_o,
  output logic                  error_o
);

  localparam logic [7:0]            MAX_COUNT = max_count(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  logic [2:0]            state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            remaining_r;
  logic [7:0]            sum_r;
  logic [3:0]            hi_nib_r;
  logic                  tmo_en_s;
  logic                  tmo_clr_s;
  logic                  tmo_tc_s;
  err_cause_e            cause_s;

  assign tmo_en_s  = (state_r != stIDLE);
  assign tmo_clr_s = rx_valid_strb_i || (state_r == stIDLE);

  loader_timeout #(
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .TIMEOUT_BITWIDTH(TIMEOUT_BITWIDTH)
  ) u_timeout (
    .clk  (clk_i),
    .reset(reset_i),
    .clr  (tmo_clr_s),
    .en   (tmo_en_s),
    .tc   (tmo_tc_s)
  );

  // Classify this cycle's abort condition; any cause other than ERR_NONE aborts the frame.
  always_comb begin
    cause_s = ERR_NONE;
    if (tmo_tc_s) begin
      cause_s = ERR_TIMEOUT;
    end else if (rx_valid_strb_i) begin
      case (state_r)
        stCOUNT: begin
          if (rx_data_i > MAX_COUNT) cause_s = ERR_RANGE;
          else                       cause_s = ERR_NONE;
        end
        stWR_LO, stWR_HI: cause_s = ERR_OVERRUN;
        stCHECK: begin
          if (rx_data_i != sum_r) cause_s = ERR_CHECKSUM;
          else                    cause_s = ERR_NONE;
        end
        default: cause_s = ERR_NONE;
      endcase
    end else begin
      cause_s = ERR_NONE;
    end
  end

  // Frame FSM with registered memory-port and status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= stIDLE;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      remaining_r <= 8'd0;
      sum_r       <= 8'd0;
      hi_nib_r    <= 4'd0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_o <= 4'd0;
      cpu_halt_o  <= 1'b0;
      load_done_o <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      mem_we_o    <= 1'b0;
      load_done_o <= 1'b0;
      if (cause_s != ERR_NONE) begin
        // Halt stays asserted and written nibbles stay in place.
        error_o <= 1'b1;
        state_r <= stIDLE;
      end else begin
        case (state_r)
          stIDLE: begin
            if (rx_valid_strb_i && (rx_data_i == SYNC_BYTE)) begin
              state_r    <= stCOUNT;
              error_o    <= 1'b0;
              cpu_halt_o <= 1'b1;
              addr_r     <= {ADDR_WIDTH{1'b0}};
              sum_r      <= 8'd0;
            end
          end
          stCOUNT: begin
            if (rx_valid_strb_i) begin
              remaining_r <= rx_data_i;
              state_r     <= (rx_data_i == 8'd0) ? stCHECK : stDATA;
            end
          end
          stDATA: begin
            if (rx_valid_strb_i) begin
              hi_nib_r    <= rx_data_i[7:4];
              sum_r       <= sum_r + rx_data_i;
              remaining_r <= remaining_r - 8'd1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= addr_r;
              mem_wdata_o <= rx_data_i[3:0];
              addr_r      <= addr_r + ADDR_ONE;
              state_r     <= stWR_LO;
            end
          end
          stWR_LO: begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= addr_r;
            mem_wdata_o <= hi_nib_r;
            addr_r      <= addr_r + ADDR_ONE;
            state_r     <= stWR_HI;
          end
          stWR_HI: begin
            state_r <= (remaining_r == 8'd0) ? stCHECK : stDATA;
          end
          stCHECK: begin
            if (rx_valid_strb_i) begin
              load_done_o <= 1'b1;
              cpu_halt_o  <= 1'b0;
              state_r     <= stIDLE;
            end
          end
          default: state_r <= stIDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: a protocol-level model predicts
// timed write/done/error/halt events; a negedge monitor compares them.
module tb_uart_prog_loader;

  localparam int         AW   = 5;
  localparam int         TC   = 40;
  localparam int         TB   = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXC = 1 << (AW - 1);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          strb = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wdata;
  logic          halt, done, err;

  uart_prog_loader #(
    .ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TC), .TIMEOUT_BITWIDTH(TB)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .rx_data_i(rx_data), .rx_valid_strb_i(strb),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .cpu_halt_o(halt), .load_done_o(done), .error_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int a; int d; } wr_t;
  typedef struct { int c; bit v; } ev_t;
  wr_t wq[$];
  int  dq[$];
  ev_t eq_err[$];
  ev_t eq_halt[$];
  int  compared = 0;
  int  mismatched = 0;

  // Reference model: frame phase (0 hunt, 1 count, 2 data, 3 checksum).
  int m_mode = 0, m_left = 0, m_addr = 0, m_sum = 0, m_last = 0, m_busy = -1;
  bit m_err = 1'b0, m_halt = 1'b0;

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_err(bit v, int e);
    if (v != m_err) eq_err.push_back('{e, v});
    m_err = v;
  endtask

  task automatic set_halt(bit v, int e);
    if (v != m_halt) eq_halt.push_back('{e, v});
    m_halt = v;
  endtask

  task automatic abort(int e);
    set_err(1'b1, e);
    m_mode = 0;
    m_busy = -1;
  endtask

  // Predict the effect of clock edge e, given whether a byte is strobed in.
  task automatic model_edge(int e, bit s, int b);
    if (!s) begin
      if (m_mode != 0 && e == m_last + TC) abort(e);
      return;
    end
    if (m_mode != 0 && e <= m_busy) begin
      if (e == m_busy - 1) void'(wq.pop_back());
      abort(e);
      return;
    end
    case (m_mode)
      0: if (b == SYNC) begin
        m_mode = 1; m_addr = 0; m_sum = 0; m_last = e;
        set_err(1'b0, e); set_halt(1'b1, e);
      end
      1: begin
        m_last = e;
        if (b > MAXC) abort(e);
        else if (b == 0) m_mode = 3;
        else begin m_left = b; m_mode = 2; end
      end
      2: begin
        m_last = e;
        wq.push_back('{e, m_addr, b % 16});
        wq.push_back('{e + 1, (m_addr + 1) % (1 << AW), b / 16});
        m_addr = (m_addr + 2) % (1 << AW);
        m_sum  = (m_sum + b) % 256;
        m_left--;
        m_mode = (m_left == 0) ? 3 : 2;
        m_busy = e + 2;
      end
      3: begin
        if (b == m_sum) begin
          dq.push_back(e); set_halt(1'b0, e); m_mode = 0;
        end else abort(e);
      end
      default: ;
    endcase
  endtask

  task automatic model_reset(int e);
    while (wq.size() > 0 && wq[$].c >= e) void'(wq.pop_back());
    set_err(1'b0, e);
    set_halt(1'b0, e);
    m_mode = 0;
    m_busy = -1;
  endtask

  // One clock: set inputs, predict the coming edge, wait past it.
  task automatic step(bit s, logic [7:0] b, bit r);
    strb = s;
    if (s) rx_data = b;
    reset_i = r;
    if (r) model_reset(cyc + 1);
    else   model_edge(cyc + 1, s, int'(b));
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(logic [7:0] b, int gap);
    idle(gap);
    step(1'b1, b, 1'b0);
  endtask

  task automatic check_quiet(string tag);
    chk({tag, "_we"}, int'(mem_we), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_halt"}, int'(halt), 0);
  endtask

  task automatic rand_frame();
    int kind = $urandom_range(0, 9);
    int n = $urandom_range(0, MAXC);
    int sum = 0;
    logic [7:0] b;
    if ($urandom_range(0, 2) == 0) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      send(b, $urandom_range(2, 5));
    end
    send(SYNC, $urandom_range(2, 5));
    if (kind == 0) begin
      send(8'($urandom_range(MAXC + 1, 255)), $urandom_range(2, 5));
      return;
    end
    send(8'(n), $urandom_range(2, 5));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      sum += int'(b);
      send(b, $urandom_range(2, 5));
      if (kind == 1 && i == 0) begin
        send(8'($urandom_range(0, 255)), $urandom_range(0, 1));
        return;
      end
    end
    if (kind == 2) send(8'(sum + $urandom_range(1, 255)), $urandom_range(2, 5));
    else           send(8'(sum), $urandom_range(2, 5));
  endtask

  // Monitor: every DUT output event must match the oldest prediction.
  bit  mon_en = 1'b0;
  bit  prev_err = 1'b0, prev_halt = 1'b0;
  wr_t mw;
  ev_t me;
  int  md;
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        if (wq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d, none expected", mem_addr, mem_wdata, cyc);
        end else begin
          mw = wq.pop_front();
          chk("write_cycle", cyc, mw.c);
          chk("write_addr", int'(mem_addr), mw.a);
          chk("write_data", int'(mem_wdata), mw.d);
        end
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
        end else begin
          md = dq.pop_front();
          chk("done_cycle", cyc, md);
        end
      end
      if (err !== prev_err) begin
        if (eq_err.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_error_edge: error_o=%b at cycle %0d, no change expected", err, cyc);
        end else begin
          me = eq_err.pop_front();
          chk("error_cycle", cyc, me.c);
          chk("error_value", int'(err), int'(me.v));
        end
        prev_err = err;
      end
      if (halt !== prev_halt) begin
        if (eq_halt.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_halt_edge: cpu_halt_o=%b at cycle %0d, no change expected", halt, cyc);
        end else begin
          me = eq_halt.pop_front();
          chk("halt_cycle", cyc, me.c);
          chk("halt_value", int'(halt), int'(me.v));
        end
        prev_halt = halt;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [7:0] b;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    chk("reset_addr", int'(mem_addr), 0);
    mon_en = 1'b1;

    // Nominal load: nibbles 1,2,3,4 at addresses 0..3.
    send(SYNC, 2); send(8'h02, 2); send(8'h21, 2); send(8'h43, 2); send(8'h64, 2);
    idle(4);
    chk("nominal_err", int'(err), 0);
    chk("nominal_halt", int'(halt), 0);

    // Bad checksum, then a good frame clears the error.
    send(SYNC, 2); send(8'h01, 2); send(8'h3C, 2); send(8'h00, 2);
    idle(4);
    chk("badsum_err", int'(err), 1);
    chk("badsum_halt", int'(halt), 1);
    send(SYNC, 2); send(8'h01, 2); send(8'h3C, 2); send(8'h3C, 2);
    idle(4);
    chk("recover_err", int'(err), 0);

    // Idle noise then an empty frame.
    send(8'h00, 2); send(8'hFF, 2); send(SYNC, 2); send(8'h00, 0); send(8'h00, 2);
    idle(4);

    // COUNT out of range.
    send(SYNC, 2); send(8'h11, 2);
    idle(4);
    chk("range_err", int'(err), 1);

    // Full-size frame: address wraps back to 0.
    send(SYNC, 2); send(8'(MAXC), 2);
    s = 0;
    for (int i = 0; i < MAXC; i++) begin
      b = 8'($urandom_range(0, 255)); s += int'(b); send(b, 2);
    end
    send(8'(s), 2);
    idle(4);

    // Overrun one and two cycles after a data strobe.
    send(SYNC, 2); send(8'h02, 2); send(8'h5A, 2); send(8'h77, 0);
    idle(4);
    send(SYNC, 2); send(8'h02, 2); send(8'h5A, 2); send(8'h77, 1);
    idle(4);

    // Timeout after one data byte.
    send(SYNC, 2); send(8'h02, 2); send(8'h21, 2);
    idle(TC + 5);
    chk("timeout_err", int'(err), 1);

    // Reset in the cycle after a data strobe, then a fresh frame.
    send(SYNC, 2); send(8'h02, 2); send(8'h21, 2);
    step(1'b0, 8'h00, 1'b1);
    check_quiet("midreset");
    idle(3);
    send(SYNC, 2); send(8'h01, 2); send(8'h98, 2); send(8'h98, 2);
    idle(4);

    for (int k = 0; k < 40; k++) begin
      rand_frame();
      idle(3);
    end
    idle(TC + 5);

    chk("pending_writes", wq.size(), 0);
    chk("pending_done", dq.size(), 0);
    chk("pending_err_edges", eq_err.size(), 0);
    chk("pending_halt_edges", eq_halt.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Downstream consumer of the UART receiver byte stream. Parses a framed program-download protocol from received bytes. Splits each data byte into two 4-bit nibbles and writes them into the CPU's nibble-wide program memory. Holds the CPU halted while a download is in progress.

Parameters:
ADDR_WIDTH, 5, program memory address width; memory depth = 2^ADDR_WIDTH nibbles
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes inside a frame (100 ms at 10 MHz)
TIMEOUT_BITWIDTH, 20, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk_i  input  1  system clock
reset_i  input  1  reset, synchronous, active-high
rx_data_i  input  8  received byte; stable from the strobe until the next strobe
rx_valid_strb_i  input  1  one-cycle pulse: rx_data_i holds a new byte
mem_we_o  output  1  program memory write enable, one cycle per nibble
mem_addr_o  output  ADDR_WIDTH  write address
mem_wdata_o  output  4  write nibble
cpu_halt_o  output  1  holds the CPU stopped during and after a failed load
load_done_o  output  1  one-cycle pulse on a successful frame
error_o  output  1  sticky error flag

Behaviour:
- Frame format: SYNC_BYTE, then COUNT (number of data bytes, 0..2^(ADDR_WIDTH-1)), then COUNT data bytes, then CHECKSUM. CHECKSUM = 8-bit modulo-256 sum of the data bytes.
- Reset (synchronous): state IDLE. Address, byte count, checksum accumulator and timeout counter = 0. All outputs = 0.
- States:
  - IDLE: on a strobe with data == SYNC_BYTE -> COUNT. On this transition clear error_o, set cpu_halt_o = 1, address = 0, sum = 0. Other bytes are ignored.
  - COUNT: on a strobe, latch COUNT. If COUNT > 2^(ADDR_WIDTH-1) -> error. If COUNT == 0 -> CHECK. Otherwise -> DATA.
  - DATA: on a strobe, latch the byte, add it to sum, decrement the remaining count -> WR_LO.
  - WR_LO: mem_we_o = 1, mem_addr_o = addr, mem_wdata_o = byte[3:0]; addr += 1 -> WR_HI.
  - WR_HI: mem_we_o = 1, mem_addr_o = addr, mem_wdata_o = byte[7:4]; addr += 1. If the remaining count == 0 -> CHECK, else -> DATA.
  - CHECK: on a strobe, if data == sum -> pulse load_done_o for one cycle, cpu_halt_o = 0, -> IDLE. Otherwise -> error.
- Write latency: a data-byte strobe in cycle t gives writes in cycles t+1 (low nibble) and t+2 (high nibble). All memory outputs are registered. mem_addr_o and mem_wdata_o are don't-care while mem_we_o = 0.
- Address arithmetic: ADDR_WIDTH bits. A legal COUNT never wraps the address; a full 2^(ADDR_WIDTH-1)-byte frame ends with addr back at 0.
- Error action, taken in one cycle, always -> IDLE:
  - error_o = 1
  - cpu_halt_o stays 1
  - load_done_o = 0
  - nibbles already written are not rolled back
- Error causes:
  - COUNT out of range
  - checksum mismatch
  - timeout
  - overrun: a strobe arriving in WR_LO or WR_HI
- Timeout: the counter runs in every state except IDLE and clears on each strobe. When it reaches TIMEOUT_CYCLES -> error.
- error_o stays set until the next accepted SYNC_BYTE or reset.
- A SYNC_BYTE value inside a frame is treated as ordinary data; there is no resynchronisation.
- Reset mid-frame aborts immediately. No write is issued in the cycle after reset. cpu_halt_o = 0 after reset.

Decomposition:
- Shared package holds:
  - state encoding: stIDLE, stCOUNT, stDATA, stWR_LO, stWR_HI, stCHECK (3 bits)
  - SYNC_BYTE default value
  - error-cause constants, for debug observability
- One sub-module is natural: loader_timeout. It is a clearable, enabled counter with a terminal-count output, parameterised by TIMEOUT_CYCLES and TIMEOUT_BITWIDTH. Everything else lives in uart_prog_loader.

Test Plan:
- Nominal load: bytes A5, 02, 21, 43, 64 -> writes addr0=1, addr1=2, addr2=3, addr3=4, each one cycle after or two cycles after its strobe. Then load_done_o pulses once, cpu_halt_o falls to 0 and error_o stays 0.
- Bad checksum: bytes A5, 01, 3C, 00 -> writes addr0=C, addr1=3. Then error_o = 1, cpu_halt_o stays 1 and load_done_o never pulses. A following good frame clears error_o.
- Empty frame and idle noise: bytes 00, FF, then A5, 00, 00 -> no writes, one load_done_o pulse, error_o = 0.
- Range and overrun: A5, 11 with ADDR_WIDTH = 5 -> error, no writes. Separately, a strobe injected one cycle after a data strobe -> error, state returns to IDLE.
- Timeout: A5, 02, 21, then no strobe for TIMEOUT_CYCLES clocks -> error_o = 1 exactly at the terminal count, state IDLE. Only addr0 and addr1 were written.
- Reset mid-frame: assert reset_i in the cycle after a data strobe -> no write in the following cycle, all outputs 0. A fresh A5 frame then loads correctly starting at addr0.
